byterate_meter: RTL and testbench

- Measures the per-source transport-stream byte rate for the 4 tuner channels over a fixed gate window.
- Publishes the results as the 128-bit byterate_bus consumed by the SPI register block, where the host reads them byte by byte.
- Sits directly upstream of the SPI register block.
- Provides a read-lock so that a multi-byte SPI read of one 32-bit value never straddles an update.

---
 rtl/byterate_meter_if.sv | 25 ++
 rtl/byterate_meter.sv | 113 +++++++++++
 tb/tb_byterate_meter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/byterate_meter_if.sv
// Bus between the byte-rate meter and its consumer: per-channel byte strobes,
// the host read-lock, and the published 4x32-bit rate results.
interface byterate_meter_if;
   logic [3:0]   byte_valid;
   logic         read_lock;
   logic [127:0] byterate_bus;
   logic         byterate_update;
   logic [3:0]   stream_active;

   modport master (
      output byte_valid,
      output read_lock,
      input  byterate_bus,
      input  byterate_update,
      input  stream_active
   );

   modport slave (
      input  byte_valid,
      input  read_lock,
      output byterate_bus,
      output byterate_update,
      output stream_active
   );
endinterface

// File: rtl/byterate_meter.sv
// Per-channel transport-stream byte counter over a fixed gate window, with a
// shadowed publish path so a host read under read_lock never sees a torn update.
module byterate_meter #(
   parameter logic [31:0] GATE_CYCLES = 32'd27000000,
   parameter int          CNT_W       = 32
) (
   input  logic              CLK,
   input  logic              RST,
   byterate_meter_if.slave   io_meter
);

   localparam int N_CH = 4;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
      logic [CNT_W-1:0] w_max;
      w_max = '1;
      if (inc && (a != w_max)) begin
         return a + CNT_W'(1);
      end else begin
         return a;
      end
   endfunction

   logic [31:0]                       r_gate;
   logic [N_CH-1:0][CNT_W-1:0]        r_acc;
   logic [N_CH-1:0][CNT_W-1:0]        r_shadow;
   logic [N_CH-1:0][CNT_W-1:0]        r_bus;
   logic [N_CH-1:0]                   r_active;
   logic                              r_pending;
   logic                              r_update;

   logic                              w_window_end;
   logic [N_CH-1:0][CNT_W-1:0]        w_result;
   logic [N_CH-1:0][CNT_W-1:0]        w_bus_nxt;
   logic [N_CH-1:0]                   w_active_nxt;
   logic                              w_publish_new;
   logic                              w_publish_shadow;
   logic                              w_stash;

   // Window detection, closing results and publish decisions
   always_comb begin
      w_window_end     = (r_gate == (GATE_CYCLES - 32'd1));
      w_result         = '0;
      w_active_nxt     = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_result[k] = sat_inc(r_acc[k], io_meter.byte_valid[k]);
      end
      // An update pulse already on the output defers any publish by one cycle,
      // so byterate_update can never be high twice in a row.
      w_publish_new    = w_window_end && !io_meter.read_lock && !r_update;
      w_stash          = w_window_end && !w_publish_new;
      w_publish_shadow = !w_window_end && r_pending && !io_meter.read_lock && !r_update;
      w_bus_nxt        = w_publish_new ? w_result : r_shadow;
      for (int k = 0; k < N_CH; k++) begin
         w_active_nxt[k] = (w_bus_nxt[k] != '0);
      end
   end

   // Gate counter: 0 .. GATE_CYCLES-1, then wrap
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_gate <= 32'd0;
      end else if (w_window_end) begin
         r_gate <= 32'd0;
      end else begin
         r_gate <= r_gate + 32'd1;
      end
   end

   // Saturating per-channel byte accumulators, cleared at window end
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_acc <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            r_acc[k] <= w_window_end ? '0 : w_result[k];
         end
      end
   end

   // Shadow/pending bookkeeping and registered output bus
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_shadow  <= '0;
         r_pending <= 1'b0;
         r_bus     <= '0;
         r_active  <= '0;
         r_update  <= 1'b0;
      end else begin
         r_update <= w_publish_new || w_publish_shadow;
         if (w_stash) begin
            r_shadow  <= w_result;
            r_pending <= 1'b1;
         end else if (w_publish_new || w_publish_shadow) begin
            r_pending <= 1'b0;
         end else begin
            r_pending <= r_pending;
         end
         if (w_publish_new || w_publish_shadow) begin
            r_bus    <= w_bus_nxt;
            r_active <= w_active_nxt;
         end else begin
            r_bus    <= r_bus;
            r_active <= r_active;
         end
      end
   end

   assign io_meter.byterate_bus    = r_bus;
   assign io_meter.byterate_update = r_update;
   assign io_meter.stream_active   = r_active;

endmodule

// File: tb/tb_byterate_meter.sv
// Directed bench for byterate_meter with a 16-cycle gate window; expected
// results are hand-counted byte totals per window.
module tb_byterate_meter;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_err;

   byterate_meter_if mif ();

   byterate_meter #(
      .GATE_CYCLES (32'd16),
      .CNT_W       (32)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .io_meter (mif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [132:0] pk(input logic u, input logic [3:0] sa,
                                       input logic [31:0] c3, input logic [31:0] c2,
                                       input logic [31:0] c1, input logic [31:0] c0);
      return {u, sa, c3, c2, c1, c0};
   endfunction

   task automatic nxt();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [132:0] expv);
      logic [132:0] obs;
      obs = {mif.byterate_update, mif.stream_active, mif.byterate_bus};
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: got upd=%b act=%b bus=%h, expected upd=%b act=%b bus=%h",
                tag, obs[132], obs[131:128], obs[127:0],
                expv[132], expv[131:128], expv[127:0]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      RST = 1'b0;
      mif.byte_valid = 4'b0000;
      mif.read_lock  = 1'b0;
      repeat (3) nxt();
      chk("reset_state", pk(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0));

      // c0: release reset, channel 0 streams every cycle
      RST = 1'b1;
      mif.byte_valid = 4'b0001;
      for (int k = 1; k <= 15; k++) begin
         nxt();
         chk("first_window_idle", pk(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0));
      end
      nxt(); // c16
      chk("first_publish", pk(1'b1, 4'b0001, 32'd0, 32'd0, 32'd0, 32'd16));
      mif.byte_valid = 4'b0100;
      for (int k = 17; k <= 31; k++) begin
         nxt();
         chk("hold_w1", pk(1'b0, 4'b0001, 32'd0, 32'd0, 32'd0, 32'd16));
         mif.byte_valid = {(k == 31), (k % 2 == 0), 2'b00};
      end
      nxt(); // c32
      chk("alt_and_last", pk(1'b1, 4'b1100, 32'd1, 32'd8, 32'd0, 32'd0));
      mif.byte_valid = 4'b1001;
      for (int k = 33; k <= 40; k++) begin
         nxt();
         chk("hold_w2", pk(1'b0, 4'b1100, 32'd1, 32'd8, 32'd0, 32'd0));
         mif.byte_valid = 4'b0001;
      end
      nxt(); // c41: window cycle 9
      RST = 1'b0;
      nxt(); // c42 = d0
      chk("mid_reset", pk(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0));
      RST = 1'b1;
      mif.byte_valid = 4'b0010;
      for (int k = 1; k <= 15; k++) begin
         nxt();
         chk("post_reset_idle", pk(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0));
         mif.byte_valid = (k < 5) ? 4'b0010 : 4'b0000;
      end
      nxt(); // d16
      chk("post_reset_pub", pk(1'b1, 4'b0010, 32'd0, 32'd0, 32'd5, 32'd0));
      mif.byte_valid = 4'b0001;

      // Lock held d26..d56 spans window ends at d31 and d47
      for (int k = 17; k <= 57; k++) begin
         nxt();
         chk("lock_hold", pk(1'b0, 4'b0010, 32'd0, 32'd0, 32'd5, 32'd0));
         mif.read_lock  = (k >= 26 && k <= 56);
         mif.byte_valid = (k <= 31) ? 4'b0001 : (k <= 34) ? 4'b0101 :
                          (k <= 38) ? 4'b0100 : 4'b0000;
      end
      nxt(); // d58
      chk("lock_release", pk(1'b1, 4'b0101, 32'd0, 32'd7, 32'd0, 32'd3));
      nxt(); // d59
      chk("single_pulse", pk(1'b0, 4'b0101, 32'd0, 32'd7, 32'd0, 32'd3));
      repeat (5) nxt(); // d64
      chk("empty_window", pk(1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0));
      mif.byte_valid = 4'b1000;

      // Lock d70..d94 covers end at d79; released exactly at window end d95
      for (int k = 65; k <= 95; k++) begin
         nxt();
         chk("lock2_hold", pk(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0));
         mif.read_lock  = (k >= 70 && k <= 94);
         mif.byte_valid = (k <= 68) ? 4'b1000 :
                          (k == 80 || k == 81) ? 4'b0010 : 4'b0000;
      end
      nxt(); // d96
      chk("release_at_end", pk(1'b1, 4'b0010, 32'd0, 32'd0, 32'd2, 32'd0));
      mif.byte_valid = 4'b0010;
      for (int k = 97; k <= 100; k++) begin
         nxt();
         chk("no_stale_shadow", pk(1'b0, 4'b0010, 32'd0, 32'd0, 32'd2, 32'd0));
      end
      force dut.r_acc = {32'h0, 32'h0, 32'hFFFF_FFFD, 32'h0};
      #1;
      release dut.r_acc;
      for (int k = 101; k <= 111; k++) begin
         nxt();
         chk("sat_hold", pk(1'b0, 4'b0010, 32'd0, 32'd0, 32'd2, 32'd0));
      end
      nxt(); // d112
      chk("saturate", pk(1'b1, 4'b0010, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0));
      repeat (16) nxt(); // d128
      chk("after_saturate", pk(1'b1, 4'b0010, 32'd0, 32'd0, 32'd16, 32'd0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
